// File: rtl/cpu_pkg.sv
// Shared multicycle-CPU encodings: FSM states, opcodes, ALU and mux selects.
// Used by control_fsm and alu_control.
package cpu_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXEC_R,
        EXEC_I,
        ALUWB,
        BRANCH,
        ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    typedef struct packed {
        logic [1:0] aluop;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal_instr;
    } ctrl_t;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter; wraps from all-ones to zero.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RISC-V main control FSM with retired-instruction counter.
// Outputs are decoded from state and mem_ready only.
module control_fsm
    import cpu_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int RESET_PC_WAIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       aluop,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WW = (RESET_PC_WAIT > 0) ? $clog2(RESET_PC_WAIT + 1) : 1;

    state_t        state;
    state_t        state_nxt;
    ctrl_t         ctrl;
    logic [WW-1:0] wait_cnt;
    logic          wait_done;
    logic          retire;
    logic          unused_zero;

    // Branch resolution happens in the datapath.
    assign unused_zero = zero;
    assign wait_done   = (wait_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= WW'(RESET_PC_WAIT);
        end else begin
            state <= state_nxt;
            if (!wait_done) begin
                wait_cnt <= wait_cnt - WW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH: begin
                if (wait_done && mem_ready) begin
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_nxt = MEMADR;
                    OP_RTYPE:          state_nxt = EXEC_R;
                    OP_ITYPE:          state_nxt = EXEC_I;
                    OP_BRANCH:         state_nxt = BRANCH;
                    default:           state_nxt = ILLEGAL;
                endcase
            end
            MEMADR: begin
                state_nxt = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                if (mem_ready) begin
                    state_nxt = MEMWB;
                end
            end
            MEMWRITE: begin
                if (mem_ready) begin
                    state_nxt = FETCH;
                end
            end
            EXEC_R, EXEC_I: state_nxt = ALUWB;
            MEMWB, ALUWB, BRANCH, ILLEGAL: state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Reset forces every output low, including the FETCH read.
    always_comb begin
        ctrl = '0;
        if (!rst) begin
            unique case (state)
                FETCH: begin
                    if (wait_done) begin
                        ctrl.mem_read  = 1'b1;
                        ctrl.alu_src_a = SRC_A_PC;
                        ctrl.alu_src_b = SRC_B_FOUR;
                        ctrl.aluop     = ALUOP_ADD;
                        ctrl.ir_write  = mem_ready;
                        ctrl.pc_write  = mem_ready;
                    end
                end
                DECODE: begin
                    ctrl.alu_src_a = SRC_A_OLDPC;
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.aluop     = ALUOP_ADD;
                end
                MEMADR: begin
                    ctrl.alu_src_a = SRC_A_RS1;
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.aluop     = ALUOP_ADD;
                end
                MEMREAD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                MEMWRITE: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                EXEC_R: begin
                    ctrl.alu_src_a = SRC_A_RS1;
                    ctrl.alu_src_b = SRC_B_RS2;
                    ctrl.aluop     = ALUOP_RTYPE;
                end
                EXEC_I: begin
                    ctrl.alu_src_a = SRC_A_RS1;
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.aluop     = ALUOP_ITYPE;
                end
                ALUWB: begin
                    ctrl.reg_write = 1'b1;
                end
                BRANCH: begin
                    ctrl.alu_src_a     = SRC_A_RS1;
                    ctrl.alu_src_b     = SRC_B_RS2;
                    ctrl.aluop         = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                end
                ILLEGAL: begin
                    ctrl.illegal_instr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign aluop         = ctrl.aluop;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ir_write      = ctrl.ir_write;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign iord          = ctrl.iord;
    assign reg_write     = ctrl.reg_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign illegal_instr = ctrl.illegal_instr;

    assign retire = (state == MEMWB) || (state == ALUWB) ||
                    (state == BRANCH) ||
                    ((state == MEMWRITE) && mem_ready);

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (retire),
        .count(instr_count)
    );

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 Parameter RESET_PC_WAIT, default 0, number of idle cycles held in FETCH after reset release before the first mem_read.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 opcode  input  7  instruction[6:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag, valid in BRANCH.
REQ-007 mem_ready  input  1  memory done; completes a read or write this cycle.
REQ-008 aluop  output  2  to alu_control: 00 ADD, 01 SUB, 10 R-type decode, 11 I-type decode.
REQ-009 alu_src_a  output  2  00 PC, 01 rs1, 10 old PC.
REQ-010 alu_src_b  output  2  00 rs2, 01 constant 4, 10 immediate.
REQ-011 Single-bit outputs: pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord (1 = data address), reg_write, mem_to_reg, illegal_instr.
REQ-012 instr_count  output  CNT_W  retired-instruction count.

Function
REQ-013 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, ILLEGAL.
REQ-014 FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, aluop=00; when mem_ready=1, ir_write=1 and pc_write=1 in that same cycle, next DECODE; otherwise hold FETCH with ir_write=pc_write=0.
REQ-015 DECODE: alu_src_a=10, alu_src_b=10, aluop=00 (branch target precompute); next state by opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXEC_R, 0010011 -> EXEC_I, 1100011 -> BRANCH, any other -> ILLEGAL.
REQ-016 MEMADR: alu_src_a=01, alu_src_b=10, aluop=00; next MEMREAD for load, MEMWRITE for store.
REQ-017 MEMREAD: mem_read=1, iord=1; hold until mem_ready=1, then MEMWB.
REQ-018 MEMWB: reg_write=1, mem_to_reg=1; next FETCH.
REQ-019 MEMWRITE: mem_write=1, iord=1; hold until mem_ready=1, then FETCH.
REQ-020 EXEC_R: alu_src_a=01, alu_src_b=00, aluop=10; EXEC_I: alu_src_a=01, alu_src_b=10, aluop=11; both next ALUWB.
REQ-021 ALUWB: reg_write=1, mem_to_reg=0; next FETCH.
REQ-022 BRANCH: alu_src_a=01, alu_src_b=00, aluop=01, pc_write_cond=1; next FETCH; the datapath, not this FSM, gates the PC update with zero.
REQ-023 ILLEGAL: illegal_instr=1 for exactly one cycle; no write strobes asserted; next FETCH.
REQ-024 Any output not listed for a state is 0; all outputs are decoded from the current state and mem_ready only.
REQ-025 instr_count increments by 1 on leaving MEMWB, MEMWRITE (on mem_ready), ALUWB or BRANCH; never on ILLEGAL; wraps from all-ones to 0.
REQ-026 mem_read and mem_write are never both 1; ir_write occurs only in FETCH.
REQ-027 Latency with zero-wait memory: R/I-type 4 cycles, load 5, store 4, branch 3.

Reset
REQ-028 While rst=1: state=FETCH, instr_count=0, every strobe output 0, and mem_read=0 even in FETCH.
REQ-029 Reset asserted mid-operation, including during a pending memory wait, aborts immediately; no write strobe appears after rst rises.
REQ-030 After rst falls, FETCH asserts mem_read once RESET_PC_WAIT cycles have elapsed.

Structure
REQ-031 State enum, the opcode constants and the aluop/alu_src encodings live in shared package cpu_pkg, also used by alu_control.
REQ-032 The counter is one sub-module, retire_counter; the FSM is a single module with separate next-state and output blocks.

Verification
REQ-033 R-type opcode 0110011, mem_ready=1 throughout -> states FETCH, DECODE, EXEC_R (aluop=10), ALUWB (reg_write=1); instr_count 0 -> 1.
REQ-034 Load 0000011, mem_ready held 0 for 3 cycles in MEMREAD -> MEMREAD held 4 cycles with mem_read=1, iord=1, then MEMWB with mem_to_reg=1.
REQ-035 BEQ 1100011 -> BRANCH with aluop=01 and pc_write_cond=1 for 1 cycle, total 3 cycles.
REQ-036 Opcode 1111111 -> illegal_instr pulses 1 cycle, no reg_write or mem_write, instr_count unchanged.
REQ-037 rst raised during MEMWRITE wait -> mem_write drops asynchronously, state FETCH, instr_count 0.
REQ-038 instr_count preloaded to all-ones via force, then one ALU instruction -> instr_count 0.
